// File: rtl/mc14500_sequencer.sv
// mc14500_sequencer: 4-phase fetch/decode/exec/writeback sequencer for an MC14500 ICU; define MC14500_SEQ_RETSTACK_EN for a one-entry JMP/RTN return register
module mc14500_sequencer (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    output logic [6:0] rom_addr,
    input  logic [7:0] rom_data,
    output logic [2:0] imux_abc,
    output logic       imux_inh,
    input  logic       imux_z,
    output logic [3:0] lu_instruction,
    output logic       lu_data_in,
    output logic       lu_strobe,
    input  logic       lu_data_out,
    input  logic       lu_write_mode,
    input  logic       lu_result,
    output logic [7:0] out_latch,
    output logic [6:0] pc
);
    typedef enum logic [1:0] {FETCH, DECODE, EXEC, WB} state_t;
    state_t state, state_nxt;
    logic [7:0] ir;
    logic skip;
    logic [6:0] pc_inc;
`ifdef MC14500_SEQ_RETSTACK_EN
    logic [6:0] ret_pc;
    logic ret_valid;
`endif
    assign pc_inc = pc + 7'd1;
    always_ff @(posedge clk) state <= !reset ? FETCH : state_nxt;
    always_comb begin
        state_nxt = state;
        rom_addr = pc;
        imux_abc = 3'd0;
        imux_inh = 1'b0;
        lu_instruction = 4'h0;
        lu_data_in = 1'b0;
        lu_strobe = 1'b0;
        case (state)
            FETCH: state_nxt = run ? DECODE : FETCH;
            DECODE: begin
                state_nxt = EXEC;
                imux_abc = rom_data[2:0];
                imux_inh = rom_data[3];
            end
            EXEC: begin
                state_nxt = WB;
                imux_abc = ir[2:0];
                imux_inh = ir[3];
                lu_instruction = ir[7:4];
                lu_strobe = !skip;
                lu_data_in = ir[3] ? out_latch[ir[2:0]] : imux_z;
            end
            default: state_nxt = FETCH;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc <= 7'd0;
            ir <= 8'h00;
            skip <= 1'b0;
            out_latch <= 8'h00;
`ifdef MC14500_SEQ_RETSTACK_EN
            ret_valid <= 1'b0;
`endif
        end else begin
            if (state == DECODE) ir <= rom_data;
            if (state == WB) begin
                pc <= pc_inc;
                // a skipped instruction only advances the pc and clears the flag
                if (skip) skip <= 1'b0;
                else begin
                    if (lu_write_mode && ir[3]) out_latch[ir[2:0]] <= lu_data_out;
                    case (ir[7:4])
                        4'hC: begin
                            pc <= {ir[3:0], 3'b000};
`ifdef MC14500_SEQ_RETSTACK_EN
                            ret_pc <= pc_inc;
                            ret_valid <= 1'b1;
`endif
                        end
                        4'hD: begin
`ifdef MC14500_SEQ_RETSTACK_EN
                            if (ret_valid) begin
                                pc <= ret_pc;
                                ret_valid <= 1'b0;
                            end
`else
                            skip <= 1'b1;
`endif
                        end
                        4'hE: skip <= skip | !lu_result;
                        default: ;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_mc14500_sequencer.sv
// tb_mc14500_sequencer: scoreboard bench; each queued item carries the inputs for one cycle and the outputs required after it
module tb_mc14500_sequencer;
    logic clk = 1'b0, reset = 1'b0, run = 1'b0;
    logic lu_data_out = 1'b0, lu_write_mode = 1'b0, lu_result = 1'b0;
    logic [6:0] rom_addr, pc;
    logic [7:0] rom_data, out_latch;
    logic [2:0] imux_abc;
    logic imux_inh, imux_z, lu_data_in, lu_strobe;
    logic [3:0] lu_instruction;
    logic [7:0] rom [128];
    logic [7:0] in_bits = 8'hA5;
    logic [31:0] obs;
    int errors = 0, checks = 0;
    typedef struct {logic [31:0] e; logic [4:0] s;} item_t;
    item_t sb[$];

    mc14500_sequencer dut (
        .clk(clk), .reset(reset), .run(run), .rom_addr(rom_addr), .rom_data(rom_data),
        .imux_abc(imux_abc), .imux_inh(imux_inh), .imux_z(imux_z),
        .lu_instruction(lu_instruction), .lu_data_in(lu_data_in), .lu_strobe(lu_strobe),
        .lu_data_out(lu_data_out), .lu_write_mode(lu_write_mode), .lu_result(lu_result),
        .out_latch(out_latch), .pc(pc)
    );

    always #5 clk = ~clk;
    assign rom_data = rom[rom_addr];
    assign imux_z = in_bits[imux_abc];
    assign obs = {rom_addr, imux_abc, imux_inh, lu_instruction, lu_data_in, lu_strobe, out_latch, pc};

    function automatic logic [31:0] ob(input logic [6:0] ra, input logic [2:0] abc, input logic inh,
                                       input logic [3:0] ins, input logic din, input logic stb,
                                       input logic [7:0] lat, input logic [6:0] p);
        return {ra, abc, inh, ins, din, stb, lat, p};
    endfunction

    function automatic logic [31:0] idle(input logic [6:0] p, input logic [7:0] lat);
        return ob(p, 3'd0, 1'b0, 4'h0, 1'b0, 1'b0, lat, p);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // queue one full instruction: DECODE, EXEC, WB, then the following FETCH; io = {write_mode, data_out, result}
    task automatic step(input logic [6:0] p, input logic [7:0] w, input logic din, input logic stb,
                        input logic [7:0] lat, input logic [6:0] np, input logic [7:0] nlat,
                        input logic r, input logic [2:0] io);
        rom[p] = w;
        sb.push_back('{ob(p, w[2:0], w[3], 4'h0, 1'b0, 1'b0, lat, p), {2'b11, io}});
        sb.push_back('{ob(p, w[2:0], w[3], w[7:4], din, stb, lat, p), {1'b1, r, io}});
        sb.push_back('{idle(p, lat), {1'b1, r, io}});
        sb.push_back('{idle(np, nlat), {1'b1, r, io}});
    endtask

    task automatic test_reset();
        item_t it;
        int n = 0;
        for (int i = 0; i < 128; i++) rom[i] = 8'h00;
        sb.push_back('{idle(7'd0, 8'h00), 5'b00000});
        sb.push_back('{idle(7'd0, 8'h00), 5'b00000});
        repeat (3) sb.push_back('{idle(7'd0, 8'h00), 5'b10000});
        while (sb.size() > 0) begin
            it = sb.pop_front();
            {reset, run, lu_write_mode, lu_data_out, lu_result} = it.s;
            tick();
            checks++;
            if (obs !== it.e) begin errors++; $display("FAIL reset[%0d]: got %h required %h", n, obs, it.e); end
            n++;
        end
    endtask

    task automatic test_fetch();
        item_t it;
        int n = 0;
        step(7'd0, 8'h1B, 1'b0, 1'b1, 8'h00, 7'd1, 8'h00, 1'b1, 3'b001);
        step(7'd1, 8'h22, 1'b1, 1'b1, 8'h00, 7'd2, 8'h00, 1'b0, 3'b001);
        repeat (2) sb.push_back('{idle(7'd2, 8'h00), 5'b10001});
        while (sb.size() > 0) begin
            it = sb.pop_front();
            {reset, run, lu_write_mode, lu_data_out, lu_result} = it.s;
            tick();
            checks++;
            if (obs !== it.e) begin errors++; $display("FAIL fetch[%0d]: got %h required %h", n, obs, it.e); end
            n++;
        end
    endtask

    task automatic test_store();
        item_t it;
        int n = 0;
        step(7'd2, 8'h8D, 1'b0, 1'b1, 8'h00, 7'd3, 8'h20, 1'b1, 3'b111);
        step(7'd3, 8'h8A, 1'b0, 1'b1, 8'h20, 7'd4, 8'h20, 1'b1, 3'b011);
        step(7'd4, 8'h8D, 1'b1, 1'b1, 8'h20, 7'd5, 8'h00, 1'b1, 3'b101);
        step(7'd5, 8'h8F, 1'b0, 1'b1, 8'h00, 7'd6, 8'h80, 1'b1, 3'b111);
        while (sb.size() > 0) begin
            it = sb.pop_front();
            {reset, run, lu_write_mode, lu_data_out, lu_result} = it.s;
            tick();
            checks++;
            if (obs !== it.e) begin errors++; $display("FAIL store[%0d]: got %h required %h", n, obs, it.e); end
            n++;
        end
    endtask

    task automatic test_jump();
        item_t it;
        int n = 0;
        sb.push_back('{idle(7'd0, 8'h00), 5'b00000});
        for (int i = 0; i < 5; i++)
            step(7'(i), 8'h00, 1'b1, 1'b1, 8'h00, 7'(i + 1), 8'h00, 1'b1, 3'b001);
        step(7'd5, 8'hC4, 1'b0, 1'b1, 8'h00, 7'd32, 8'h00, 1'b1, 3'b001);
`ifdef MC14500_SEQ_RETSTACK_EN
        step(7'd32, 8'hD0, 1'b1, 1'b1, 8'h00, 7'd6, 8'h00, 1'b1, 3'b001);
        step(7'd6, 8'hD0, 1'b1, 1'b1, 8'h00, 7'd7, 8'h00, 1'b1, 3'b001);
`else
        step(7'd32, 8'hD0, 1'b1, 1'b1, 8'h00, 7'd33, 8'h00, 1'b1, 3'b001);
        step(7'd33, 8'hC4, 1'b0, 1'b0, 8'h00, 7'd34, 8'h00, 1'b1, 3'b001);
        step(7'd34, 8'h00, 1'b1, 1'b1, 8'h00, 7'd35, 8'h00, 1'b1, 3'b001);
`endif
        while (sb.size() > 0) begin
            it = sb.pop_front();
            {reset, run, lu_write_mode, lu_data_out, lu_result} = it.s;
            tick();
            checks++;
            if (obs !== it.e) begin errors++; $display("FAIL jump[%0d]: got %h required %h", n, obs, it.e); end
            n++;
        end
    endtask

    task automatic test_skip();
        item_t it;
        int n = 0;
        sb.push_back('{idle(7'd0, 8'h00), 5'b00000});
        step(7'd0, 8'hC1, 1'b0, 1'b1, 8'h00, 7'd8, 8'h00, 1'b1, 3'b001);
        step(7'd8, 8'h00, 1'b1, 1'b1, 8'h00, 7'd9, 8'h00, 1'b1, 3'b001);
        step(7'd9, 8'h00, 1'b1, 1'b1, 8'h00, 7'd10, 8'h00, 1'b1, 3'b001);
        step(7'd10, 8'hE0, 1'b1, 1'b1, 8'h00, 7'd11, 8'h00, 1'b1, 3'b000);
        step(7'd11, 8'hC4, 1'b0, 1'b0, 8'h00, 7'd12, 8'h00, 1'b1, 3'b001);
        step(7'd12, 8'hE0, 1'b1, 1'b1, 8'h00, 7'd13, 8'h00, 1'b1, 3'b001);
        step(7'd13, 8'h00, 1'b1, 1'b1, 8'h00, 7'd14, 8'h00, 1'b1, 3'b001);
        step(7'd14, 8'hE0, 1'b1, 1'b1, 8'h00, 7'd15, 8'h00, 1'b1, 3'b000);
        step(7'd15, 8'h8D, 1'b0, 1'b0, 8'h00, 7'd16, 8'h00, 1'b1, 3'b111);
        step(7'd16, 8'h00, 1'b1, 1'b1, 8'h00, 7'd17, 8'h00, 1'b1, 3'b001);
        while (sb.size() > 0) begin
            it = sb.pop_front();
            {reset, run, lu_write_mode, lu_data_out, lu_result} = it.s;
            tick();
            checks++;
            if (obs !== it.e) begin errors++; $display("FAIL skip[%0d]: got %h required %h", n, obs, it.e); end
            n++;
        end
    endtask

    task automatic test_wrap_and_reset();
        item_t it;
        int n = 0;
        sb.push_back('{idle(7'd0, 8'h00), 5'b00000});
        step(7'd0, 8'h8D, 1'b0, 1'b1, 8'h00, 7'd1, 8'h20, 1'b1, 3'b111);
        step(7'd1, 8'hCF, 1'b0, 1'b1, 8'h20, 7'd120, 8'h20, 1'b1, 3'b001);
        for (int a = 120; a < 127; a++)
            step(7'(a), 8'h00, 1'b1, 1'b1, 8'h20, 7'(a + 1), 8'h20, 1'b1, 3'b001);
        step(7'd127, 8'h00, 1'b1, 1'b1, 8'h20, 7'd0, 8'h20, 1'b1, 3'b001);
        // re-run the store at 0 and pull reset low while it is in EXEC
        sb.push_back('{ob(7'd0, 3'd5, 1'b1, 4'h0, 1'b0, 1'b0, 8'h20, 7'd0), 5'b11111});
        sb.push_back('{ob(7'd0, 3'd5, 1'b1, 4'h8, 1'b1, 1'b1, 8'h20, 7'd0), 5'b11111});
        sb.push_back('{idle(7'd0, 8'h00), 5'b01111});
        sb.push_back('{idle(7'd0, 8'h00), 5'b10000});
        while (sb.size() > 0) begin
            it = sb.pop_front();
            {reset, run, lu_write_mode, lu_data_out, lu_result} = it.s;
            tick();
            checks++;
            if (obs !== it.e) begin errors++; $display("FAIL wrap_reset[%0d]: got %h required %h", n, obs, it.e); end
            n++;
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_store();
        test_jump();
        test_skip();
        test_wrap_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
